// File: rtl/vga_pkg.sv
// Shared constants, types and colour helpers for the VGA pixel fetch path.
package vga_pkg;

  localparam int H_RES_HALF = 320;
  localparam int V_RES_HALF = 240;
  localparam int BAR_W      = H_RES_HALF / 8;

  typedef logic [16:0] fb_addr_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // One entry of the sync/blank pipe that travels alongside the RAM read.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       mode;
    logic [2:0] bar;
  } pipe_t;

  localparam pipe_t PIPE_RST = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0, mode: 1'b0, bar: 3'd0};

  localparam logic [11:0] BAR_TABLE [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    rgb444_t c;
    c = BAR_TABLE[idx];
    return c;
  endfunction

  function automatic rgb444_t rgb332_to_444(input logic [7:0] d);
    rgb444_t c;
    c.r = {d[7:5], d[7]};
    c.g = {d[4:2], d[4]};
    c.b = {d[1:0], d[1:0]};
    return c;
  endfunction

  // Column to bar index by threshold compares; anything past the last bar is 7.
  function automatic logic [2:0] bar_index(input logic [8:0] x);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (x < 9'(BAR_W * (i + 1))) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a per-entry reset value.
module vga_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer / test-bar colour fetch with sync re-timing; input to DAC latency RD_LAT+2 clocks.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int       RD_LAT  = 1,
  parameter fb_addr_t FB_BASE = 17'h00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  pixel_x,
  input  logic [7:0]  pixel_y,
  input  logic        blank_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        mode_sel,
  output logic [16:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [7:0]  fb_rd_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  logic     vsync_in_q;
  logic     mode_eff;
  logic     rd_next;
  fb_addr_t addr_next;
  pipe_t    pipe_in;
  pipe_t    tap;
  rgb444_t  colour_next;
  logic     vs_fall_out;

  // Mode only changes on the vsync fall, so a frame is never split between sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_in_q <= 1'b1;
      mode_eff   <= 1'b0;
    end else begin
      vsync_in_q <= vsync_in;
      if (vsync_in_q && !vsync_in) mode_eff <= mode_sel;
    end
  end

  always_comb begin
    addr_next = FB_BASE + (fb_addr_t'(pixel_y) << 8) + (fb_addr_t'(pixel_y) << 6)
              + fb_addr_t'(pixel_x);
    rd_next   = blank_in & ~mode_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_rd_en <= 1'b0;
      fb_addr  <= FB_BASE;
    end else begin
      fb_rd_en <= rd_next;
      if (rd_next) fb_addr <= addr_next;
    end
  end

  always_comb begin
    pipe_in       = PIPE_RST;
    pipe_in.hsync = hsync_in;
    pipe_in.vsync = vsync_in;
    pipe_in.blank = blank_in;
    pipe_in.mode  = mode_eff;
    pipe_in.bar   = bar_index(pixel_x);
  end

  // Tap lines up with fb_rd_data; the output register adds the final clock.
  vga_delay_line #(
    .DEPTH   (RD_LAT + 1),
    .WIDTH   ($bits(pipe_t)),
    .RST_VAL (PIPE_RST)
  ) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (tap)
  );

  always_comb begin
    colour_next = '0;
    if (tap.blank) begin
      if (tap.mode) colour_next = bar_colour(tap.bar);
      else          colour_next = rgb332_to_444(fb_rd_data);
    end
  end

  // vsync_out doubles as the previous-vsync register for the frame edge detector.
  assign vs_fall_out = vsync_out & ~tap.vsync;

  always_ff @(posedge clk) begin
    if (rst) begin
      red         <= 4'd0;
      green       <= 4'd0;
      blue        <= 4'd0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      blank_out   <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      red         <= colour_next.r;
      green       <= colour_next.g;
      blue        <= colour_next.b;
      hsync_out   <= tap.hsync;
      vsync_out   <= tap.vsync;
      blank_out   <= tap.blank;
      frame_start <= vs_fall_out;
      if (vs_fall_out) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: two instances (RD_LAT 1 and 3) against a cycle-history reference model.
module tb_vga_pixel_fetch;

  localparam int          LAT0  = 1;
  localparam int          LAT1  = 3;
  localparam logic [16:0] BASE0 = 17'h00000;
  localparam logic [16:0] BASE1 = 17'h1F000;
  localparam int          HR    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [8:0]  pixel_x;
  logic [7:0]  pixel_y;
  logic        blank_in, hsync_in, vsync_in, mode_sel;

  logic [16:0] fb_addr     [2];
  logic        fb_rd_en    [2];
  logic [7:0]  fb_rd_data  [2];
  logic [3:0]  red         [2];
  logic [3:0]  green       [2];
  logic [3:0]  blue        [2];
  logic        hsync_out   [2];
  logic        vsync_out   [2];
  logic        blank_out   [2];
  logic        frame_start [2];
  logic [7:0]  frame_cnt   [2];

  vga_pixel_fetch #(.RD_LAT(LAT0), .FB_BASE(BASE0)) dut0 (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .blank_in(blank_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_sel(mode_sel),
    .fb_addr(fb_addr[0]), .fb_rd_en(fb_rd_en[0]), .fb_rd_data(fb_rd_data[0]),
    .red(red[0]), .green(green[0]), .blue(blue[0]),
    .hsync_out(hsync_out[0]), .vsync_out(vsync_out[0]), .blank_out(blank_out[0]),
    .frame_start(frame_start[0]), .frame_cnt(frame_cnt[0]));

  vga_pixel_fetch #(.RD_LAT(LAT1), .FB_BASE(BASE1)) dut1 (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .blank_in(blank_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_sel(mode_sel),
    .fb_addr(fb_addr[1]), .fb_rd_en(fb_rd_en[1]), .fb_rd_data(fb_rd_data[1]),
    .red(red[1]), .green(green[1]), .blue(blue[1]),
    .hsync_out(hsync_out[1]), .vsync_out(vsync_out[1]), .blank_out(blank_out[1]),
    .frame_start(frame_start[1]), .frame_cnt(frame_cnt[1]));

  // RAM models: mem[a] = a[7:0]; garbage is returned for cycles without a strobe.
  logic [7:0] rp0;
  logic [7:0] rp1 [3];
  always @(posedge clk) begin
    rp0    <= fb_rd_en[0] ? fb_addr[0][7:0] : 8'($urandom);
    rp1[0] <= fb_rd_en[1] ? fb_addr[1][7:0] : 8'($urandom);
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign fb_rd_data[0] = rp0;
  assign fb_rd_data[1] = rp1[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          h_x     [HR];
  int          h_y     [HR];
  bit          h_blank [HR];
  bit          h_hs    [HR];
  bit          h_vs    [HR];
  bit          h_meff  [HR];
  bit          h_rst   [HR];
  bit          m_mode;
  bit          m_vsprev;
  bit          msel;
  bit          e_vs_prev [2];
  logic [7:0]  e_cnt     [2];
  logic [16:0] e_addr    [2];
  logic [11:0] bar_tab   [8];

  function automatic int idx(input int n);
    return ((n % HR) + HR) % HR;
  endfunction

  function automatic logic [16:0] ref_addr(input logic [16:0] base, input int x, input int y);
    int a;
    a = int'(base) + y * 320 + x;
    return 17'(a);
  endfunction

  function automatic logic [11:0] ref_fb_colour(input logic [7:0] b);
    return {b[7:5], b[7], b[4:2], b[4], b[1:0], b[1:0]};
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
      if (bad >= 200) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  // Drive one clock of inputs and advance the mode model past that clock's edge.
  task automatic step(input int x, input int y, input bit b, input bit hs, input bit vs,
                      input bit ms, input bit r);
    int k;
    @(posedge clk);
    #1;
    cyc++;
    k = idx(cyc);
    pixel_x = 9'(x); pixel_y = 8'(y); blank_in = b; hsync_in = hs; vsync_in = vs;
    mode_sel = ms; rst = r;
    h_x[k] = x; h_y[k] = y; h_blank[k] = b; h_hs[k] = hs; h_vs[k] = vs; h_rst[k] = r;
    h_meff[k] = m_mode;
    if (r) begin
      m_mode = 1'b0; m_vsprev = 1'b1;
    end else begin
      if (m_vsprev && !vs) m_mode = ms;
      m_vsprev = vs;
    end
  endtask

  task automatic idle(input int n, input bit ms);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b1, 1'b1, ms, 1'b0);
  endtask

  task automatic check_dut(input int d);
    int          lat, s, p;
    bit          flushed, ehs, evs, eb, erd, efs;
    logic [11:0] ecol;
    logic [16:0] base, ra;
    lat  = (d == 0) ? LAT0 + 2 : LAT1 + 2;
    base = (d == 0) ? BASE0 : BASE1;
    flushed = 1'b0;
    for (int j = 1; j <= lat; j++) if (h_rst[idx(cyc - j)]) flushed = 1'b1;
    s = idx(cyc - lat);
    p = idx(cyc - 1);
    if (flushed) begin
      ehs = 1'b1; evs = 1'b1; eb = 1'b0; ecol = 12'h000;
    end else begin
      ehs = h_hs[s]; evs = h_vs[s]; eb = h_blank[s];
      ra  = ref_addr(base, h_x[s], h_y[s]);
      if (!eb)            ecol = 12'h000;
      else if (h_meff[s]) ecol = bar_tab[h_x[s] / 40];
      else                ecol = ref_fb_colour(ra[7:0]);
    end
    if (h_rst[p]) begin
      erd = 1'b0; e_addr[d] = base;
    end else begin
      erd = h_blank[p] && !h_meff[p];
      if (erd) e_addr[d] = ref_addr(base, h_x[p], h_y[p]);
    end
    efs = e_vs_prev[d] && !evs;
    if (h_rst[p]) e_cnt[d] = 8'd0;
    else if (efs) e_cnt[d] = e_cnt[d] + 8'd1;
    e_vs_prev[d] = evs;

    chk("hsync_out",   d, 32'(hsync_out[d]),   32'(ehs));
    chk("vsync_out",   d, 32'(vsync_out[d]),   32'(evs));
    chk("blank_out",   d, 32'(blank_out[d]),   32'(eb));
    chk("rgb",         d, 32'({red[d], green[d], blue[d]}), 32'(ecol));
    chk("fb_rd_en",    d, 32'(fb_rd_en[d]),    32'(erd));
    chk("fb_addr",     d, 32'(fb_addr[d]),     32'(e_addr[d]));
    chk("frame_start", d, 32'(frame_start[d]), 32'(efs));
    chk("frame_cnt",   d, 32'(frame_cnt[d]),   32'(e_cnt[d]));
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int d = 0; d < 2; d++) check_dut(d);
    end
  end

  function automatic int rand_y();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 0;
    if (r == 1) return 239;
    return $urandom_range(0, 239);
  endfunction

  // Shortened frames: full 800-clock lines, few lines, vsync on the second-last line.
  task automatic run_frame(input int nlines);
    for (int l = 0; l < nlines; l++) begin
      bit act, vs;
      int y, rst_h, flip_h;
      act    = (l < nlines - 3);
      vs     = (l != nlines - 2);
      y      = act ? rand_y() : 240 + l;
      rst_h  = (l == 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 799)) : -1;
      flip_h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 799)) : -1;
      for (int h = 0; h < 800; h++) begin
        int x;
        x = (h < 640) ? h / 2 : 320 + (h - 640) / 2;
        if (h == flip_h) msel = ~msel;
        step(x, y, act && (h < 640), !(h >= 656 && h < 752), vs, msel, h == rst_h);
      end
    end
  endtask

  int          xs   [7];
  logic [11:0] xexp [7];

  initial begin
    rst = 1'b1; pixel_x = '0; pixel_y = '0; blank_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; mode_sel = 1'b0;
    for (int i = 0; i < HR; i++) begin
      h_x[i] = 0; h_y[i] = 0; h_blank[i] = 1'b0; h_hs[i] = 1'b1; h_vs[i] = 1'b1;
      h_meff[i] = 1'b0; h_rst[i] = 1'b1;
    end
    m_mode = 1'b0; m_vsprev = 1'b1; msel = 1'b0;
    for (int d = 0; d < 2; d++) begin
      e_vs_prev[d] = 1'b1; e_cnt[d] = 8'd0;
    end
    e_addr[0] = BASE0; e_addr[1] = BASE1;
    bar_tab = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    xs   = '{0, 39, 40, 80, 279, 280, 319};
    xexp = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h00F, 12'h000, 12'h000};

    // Reset state.
    for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst_addr0", 0, 32'(fb_addr[0]), 32'd0);
    chk("rst_addr1", 1, 32'(fb_addr[1]), 32'h1F000);
    chk("rst_hsync", 0, 32'(hsync_out[0]), 32'd1);
    chk("rst_blank", 0, 32'(blank_out[0]), 32'd0);
    chk("rst_fcnt",  0, 32'(frame_cnt[0]), 32'd0);
    idle(3, 1'b0);

    // (5,2) framebuffer pixel: address one clock later, colour three clocks later.
    step(5, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("addr_645",  0, 32'(fb_addr[0]), 32'd645);
    chk("rd_en_645", 0, 32'(fb_rd_en[0]), 32'd1);
    chk("addr_base", 1, 32'(fb_addr[1]), 32'h1F285);
    idle(2, 1'b0);
    @(negedge clk);
    chk("rgb_0x85", 0, 32'({red[0], green[0], blue[0]}), 32'h925);

    // RD_LAT=3 corner pixel with address carry dropped.
    idle(2, 1'b0);
    step(319, 239, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(319, 239, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("addr_corner", 1, 32'(fb_addr[1]), 32'd72703);
    idle(3, 1'b0);
    @(negedge clk);
    chk("blank_pre", 1, 32'(blank_out[1]), 32'd0);
    idle(1, 1'b0);
    @(negedge clk);
    chk("blank_lat5", 1, 32'(blank_out[1]), 32'd1);
    chk("rgb_corner", 1, 32'({red[1], green[1], blue[1]}), 32'hFFF);

    // Mid-frame mode request is ignored until the vsync fall.
    idle(2, 1'b1);
    step(40, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    @(negedge clk);
    chk("mode_held", 0, 32'({red[0], green[0], blue[0]}), 32'h240);
    step(0, 245, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(0, 245, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(xs[i], 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      @(negedge clk);
      chk("bar", 0, 32'({red[0], green[0], blue[0]}), 32'(xexp[i]));
    end
    msel = 1'b1;

    // Randomised frames with mode flips and occasional mid-line resets.
    for (int f = 0; f < 7; f++) run_frame(8);

    // Single-clock reset in the middle of active video.
    for (int i = 0; i < 3; i++) step(10, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(10, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(10, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rstm_hsync", 0, 32'(hsync_out[0]), 32'd1);
    chk("rstm_blank", 0, 32'(blank_out[0]), 32'd0);
    chk("rstm_rgb",   0, 32'({red[0], green[0], blue[0]}), 32'h000);
    chk("rstm_rd_en", 0, 32'(fb_rd_en[0]), 32'd0);
    chk("rstm_fs",    0, 32'(frame_start[0]), 32'd0);
    step(10, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(10, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rstm_flush", 0, 32'(blank_out[0]), 32'd0);
    step(10, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rstm_resume", 0, 32'(blank_out[0]), 32'd1);

    // Frame counter wrap via short vsync pulses.
    for (int i = 0; i < 255; i++) begin
      idle(3, 1'b0);
      step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(8, 1'b0);
    @(negedge clk);
    chk("fcnt_255", 0, 32'(frame_cnt[0]), 32'd255);
    chk("fcnt_255", 1, 32'(frame_cnt[1]), 32'd255);
    idle(3, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8, 1'b0);
    @(negedge clk);
    chk("fcnt_wrap", 0, 32'(frame_cnt[0]), 32'd0);
    chk("fcnt_wrap", 1, 32'(frame_cnt[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
